fm_guard_gen_ctrl: RTL and testbench

Sequencer for the feature-map/guard generation stage. It accepts partial-sum beats from the PE array through a valid/ready handshake and produces the per-beat loop indices that the stage consumes: width, height and input-channel counters, row-phase flags and the `count_3` rotation. It also produces `psum_almost_valid` and throttles the array so that a new output map never starts while the previous ping-pong half is still being written back. After the last output map it issues a flush beat so that the final write-back is launched.

---
 rtl/diff_core_pkg.sv | 18 +
 rtl/fm_ctrl_dim_cnt.sv | 27 ++
 rtl/fm_guard_gen_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fm_guard_gen_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/diff_core_pkg.sv
// Shared definitions for the feature-map/guard generation stage: controller
// state encoding, the common counter width and a mod-3 step helper.
package diff_core_pkg;

   localparam int FM_CTRL_CNT_W = 8;

   typedef enum logic [1:0] {
      FM_IDLE  = 2'd0,
      FM_RUN   = 2'd1,
      FM_FLUSH = 2'd2,
      FM_DRAIN = 2'd3
   } fm_ctrl_state_e;

   function automatic logic [1:0] mod3_step(input logic [1:0] m);
      return (m == 2'd2) ? 2'd0 : m + 2'd1;
   endfunction

endpackage

// File: rtl/fm_ctrl_dim_cnt.sv
// One loop dimension: counts enabled steps from 0 to max and wraps, flagging
// the wrap combinationally so the next outer dimension can be chained on it.
module fm_ctrl_dim_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] max,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   assign wrap = en & (cnt == max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fm_guard_gen_ctrl.sv
// Loop-index sequencer for the fm/guard generation stage with write-back
// throttling at output-map boundaries. Optional counters: FM_GUARD_CTRL_PERF_EN.
module fm_guard_gen_ctrl
   import diff_core_pkg::*;
#(
   parameter int CNT_W = FM_CTRL_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] w_num,
   input  logic [CNT_W-1:0] h_num,
   input  logic [CNT_W-1:0] c_num,
   input  logic [CNT_W-1:0] o_num,
   input  logic             kernal_mode,
   // Beat moves when psum_in_valid & psum_in_ready in the same cycle; ready never
   // looks at valid, and a producer keeps valid/data steady until accepted.
   input  logic             psum_in_valid,
   output logic             psum_in_ready,
   input  logic             write_back_finish,
   output logic             psum_almost_valid,
   output logic             psum_flush,
   output logic [CNT_W-1:0] count_w,
   output logic [CNT_W-1:0] count_h,
   output logic [CNT_W-1:0] count_c,
   output logic [1:0]       count_3,
   output logic             tick_tock,
   output logic             is_even_even_row,
   output logic             kernal_mode_o,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
`ifdef FM_GUARD_CTRL_PERF_EN
   output logic [31:0]      perf_beats,
   output logic [31:0]      perf_stall,
`endif
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] S_IDLE  = FM_IDLE;
   localparam logic [1:0] S_RUN   = FM_RUN;
   localparam logic [1:0] S_FLUSH = FM_FLUSH;
   localparam logic [1:0] S_DRAIN = FM_DRAIN;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] w_max_q, h_max_q, c_max_q, o_max_q;
   logic [CNT_W-1:0] nw, nh, nc, no;
   logic             w_wrap, h_wrap, c_wrap, o_wrap;
   logic [1:0]       n3_q;
   logic             wb_busy_q;
   logic             cfg_ok, start_acc, start_rej;
   logic             first, hs, flush_fire, last;
   logic             unused_no;

   assign cfg_ok    = (w_num != '0) && (h_num != '0) && (c_num != '0) && (o_num != '0);
   assign start_acc = start & (state_q == S_IDLE) & cfg_ok;
   assign start_rej = start & (state_q == S_IDLE) & ~cfg_ok;

   assign first         = (nw == '0) && (nh == '0) && (nc == '0);
   assign psum_in_ready = (state_q == S_RUN) & ~(first & wb_busy_q);
   assign hs            = psum_in_valid & psum_in_ready;
   assign flush_fire    = (state_q == S_FLUSH) & ~wb_busy_q;
   assign last          = o_wrap;

   assign psum_almost_valid = hs | flush_fire;
   assign psum_flush        = flush_fire;
   assign busy              = (state_q != S_IDLE);
   assign state_dbg         = state_q;
   assign unused_no         = &{1'b0, no};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_max_q       <= '0;
         h_max_q       <= '0;
         c_max_q       <= '0;
         o_max_q       <= '0;
         kernal_mode_o <= 1'b0;
      end else if (start_acc) begin
         w_max_q       <= w_num - CNT_W'(1);
         h_max_q       <= h_num - CNT_W'(1);
         c_max_q       <= c_num - CNT_W'(1);
         o_max_q       <= o_num - CNT_W'(1);
         kernal_mode_o <= kernal_mode;
      end
   end

   // nw is innermost; each outer dimension steps on the wrap of the one inside it.
   fm_ctrl_dim_cnt #(.CNT_W(CNT_W)) u_cnt_w (
      .clk(clk), .rst_n(rst_n), .en(hs), .clr(start_acc), .max(w_max_q), .cnt(nw), .wrap(w_wrap)
   );
   fm_ctrl_dim_cnt #(.CNT_W(CNT_W)) u_cnt_h (
      .clk(clk), .rst_n(rst_n), .en(w_wrap), .clr(start_acc), .max(h_max_q), .cnt(nh), .wrap(h_wrap)
   );
   fm_ctrl_dim_cnt #(.CNT_W(CNT_W)) u_cnt_c (
      .clk(clk), .rst_n(rst_n), .en(h_wrap), .clr(start_acc), .max(c_max_q), .cnt(nc), .wrap(c_wrap)
   );
   fm_ctrl_dim_cnt #(.CNT_W(CNT_W)) u_cnt_o (
      .clk(clk), .rst_n(rst_n), .en(c_wrap), .clr(start_acc), .max(o_max_q), .cnt(no), .wrap(o_wrap)
   );

   // Running nh mod 3 avoids a divider on the row index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n3_q <= 2'd0;
      end else if (start_acc) begin
         n3_q <= 2'd0;
      end else if (w_wrap) begin
         n3_q <= h_wrap ? 2'd0 : mod3_step(n3_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_busy_q <= 1'b0;
      end else if ((hs & first) | flush_fire) begin
         wb_busy_q <= 1'b1;
      end else if (write_back_finish) begin
         wb_busy_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_w          <= '0;
         count_h          <= '0;
         count_c          <= '0;
         count_3          <= 2'd0;
         tick_tock        <= 1'b0;
         is_even_even_row <= 1'b0;
      end else if (hs) begin
         count_w          <= nw;
         count_h          <= nh;
         count_c          <= nc;
         count_3          <= n3_q;
         tick_tock        <= nh[0];
         is_even_even_row <= nh[1];
      end else if (flush_fire) begin
         count_w          <= '0;
         count_h          <= '0;
         count_c          <= '0;
         count_3          <= 2'd0;
         tick_tock        <= 1'b0;
         is_even_even_row <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_acc) state_d = S_RUN;
         S_RUN:   if (last) state_d = S_FLUSH;
         S_FLUSH: if (flush_fire) state_d = S_DRAIN;
         S_DRAIN: if (write_back_finish & wb_busy_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         done    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == S_DRAIN) & write_back_finish & wb_busy_q;
         cfg_err <= start_rej;
      end
   end

`ifdef FM_GUARD_CTRL_PERF_EN
   logic run_or_flush;
   assign run_or_flush = (state_q == S_RUN) | (state_q == S_FLUSH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_beats <= '0;
         perf_stall <= '0;
      end else if (start_acc) begin
         perf_beats <= '0;
         perf_stall <= '0;
      end else begin
         if (hs && (perf_beats != '1)) perf_beats <= perf_beats + 32'd1;
         if (run_or_flush && psum_in_valid && !psum_almost_valid && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fm_guard_gen_ctrl.sv
// Bench for fm_guard_gen_ctrl: jobs are modelled as a flat beat index decoded
// into loop indices, plus a write-back responder with a programmable delay.
module tb_fm_guard_gen_ctrl;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] w_num = '0, h_num = '0, c_num = '0, o_num = '0;
   logic          kernal_mode = 1'b0;
   logic          psum_in_valid = 1'b0;
   logic          write_back_finish = 1'b0;
   logic          psum_in_ready, psum_almost_valid, psum_flush;
   logic [CW-1:0] count_w, count_h, count_c;
   logic [1:0]    count_3;
   logic          tick_tock, is_even_even_row, kernal_mode_o;
   logic          busy, done, cfg_err;
   logic [1:0]    state_dbg;
`ifdef FM_GUARD_CTRL_PERF_EN
   logic [31:0]   perf_beats, perf_stall;
`endif

   always #5 clk = ~clk;

   fm_guard_gen_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .w_num(w_num), .h_num(h_num), .c_num(c_num), .o_num(o_num),
      .kernal_mode(kernal_mode),
      .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
      .write_back_finish(write_back_finish),
      .psum_almost_valid(psum_almost_valid), .psum_flush(psum_flush),
      .count_w(count_w), .count_h(count_h), .count_c(count_c), .count_3(count_3),
      .tick_tock(tick_tock), .is_even_even_row(is_even_even_row),
      .kernal_mode_o(kernal_mode_o), .busy(busy), .done(done), .cfg_err(cfg_err),
`ifdef FM_GUARD_CTRL_PERF_EN
      .perf_beats(perf_beats), .perf_stall(perf_stall),
`endif
      .state_dbg(state_dbg)
   );

   int checks = 0;
   int errors = 0;

   // scoreboard: beat indices {c,h,w} expected on the outputs one cycle later
   logic [3*CW-1:0] exp_q[$];

   logic [CW-1:0] e_w = '0, e_h = '0, e_c = '0;
   logic          e_km = 1'b0, e_done = 1'b0, e_cfg_err = 1'b0, e_busy = 1'b0;
   bit            wb_pend = 1'b0, fin_armed = 1'b0;
   int            fin_timer = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input bit er, input bit ea, input bit ef);
      logic [3*CW-1:0] b;
      if (exp_q.size() > 0) begin
         b   = exp_q.pop_front();
         e_w = b[CW-1:0];
         e_h = b[2*CW-1:CW];
         e_c = b[3*CW-1:2*CW];
      end
      chk("psum_in_ready", 32'(psum_in_ready), 32'(er));
      chk("psum_almost_valid", 32'(psum_almost_valid), 32'(ea));
      chk("psum_flush", 32'(psum_flush), 32'(ef));
      chk("count_w", 32'(count_w), 32'(e_w));
      chk("count_h", 32'(count_h), 32'(e_h));
      chk("count_c", 32'(count_c), 32'(e_c));
      chk("count_3", 32'(count_3), 32'(e_h) % 3);
      chk("tick_tock", 32'(tick_tock), 32'(e_h) % 2);
      chk("is_even_even_row", 32'(is_even_even_row), (32'(e_h) / 2) % 2);
      chk("kernal_mode_o", 32'(kernal_mode_o), 32'(e_km));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("cfg_err", 32'(cfg_err), 32'(e_cfg_err));
      chk("state_idle", 32'(state_dbg == 2'd0), 32'(!e_busy));
   endtask

   task automatic model_reset();
      exp_q.delete();
      e_w = '0; e_h = '0; e_c = '0; e_km = 1'b0;
      e_done = 1'b0; e_cfg_err = 1'b0; e_busy = 1'b0;
      wb_pend = 1'b0; fin_armed = 1'b0; fin_timer = 0;
   endtask

   task automatic run_job(input int w, input int h, input int c, input int o,
                          input int vpct, input int fdel, input int abort_at,
                          input bit rand_start);
      int total, mapsz, beat, cyc, stalls, wi, hi, ci;
      bit flushed, ended, run_ph, fl_ph, dr_ph, hs, set_wb, fin, er, ef;
      logic km;
      total = w * h * c * o;
      mapsz = w * h * c;
      beat = 0; cyc = 0; stalls = 0;
      flushed = 0; ended = 0;
      km = 1'($urandom_range(0, 1));

      @(negedge clk);
      start = 1'b1; w_num = CW'(w); h_num = CW'(h); c_num = CW'(c); o_num = CW'(o);
      kernal_mode = km; psum_in_valid = 1'b1; write_back_finish = 1'b0;
      #1;
      check_outputs(1'b0, 1'b0, 1'b0);
      e_busy = 1'b1; e_km = km; e_done = 1'b0; e_cfg_err = 1'b0;

      while (!ended && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (fin_armed && fin_timer > 0) fin_timer--;
         fin = fin_armed && (fin_timer == 0);
         write_back_finish = fin;
         run_ph = (beat < total);
         fl_ph  = !run_ph && !flushed;
         dr_ph  = flushed;
         psum_in_valid = ($urandom_range(0, 99) < vpct);
         start = rand_start && ($urandom_range(0, 7) == 0);
         w_num = CW'($urandom); h_num = CW'($urandom);
         c_num = CW'($urandom); o_num = CW'($urandom);
         kernal_mode = 1'($urandom_range(0, 1));
         #1;
         er = run_ph && !(((beat % mapsz) == 0) && wb_pend);
         hs = er && psum_in_valid;
         ef = fl_ph && !wb_pend;
         check_outputs(er, hs || ef, ef);

         set_wb = 0;
         if (hs) begin
            wi = beat % w;
            hi = (beat / w) % h;
            ci = (beat / (w * h)) % c;
            exp_q.push_back({CW'(ci), CW'(hi), CW'(wi)});
            if ((beat % mapsz) == 0) set_wb = 1;
            beat++;
         end
         if (ef) begin
            exp_q.push_back('0);
            flushed = 1;
            set_wb = 1;
         end
         if ((run_ph || fl_ph) && psum_in_valid && !(hs || ef)) stalls++;
         e_done = 1'b0;
         if (fin) begin
            fin_armed = 0;
            if (!set_wb) wb_pend = 0;
            if (dr_ph) begin
               e_done = 1'b1;
               e_busy = 1'b0;
               ended  = 1;
            end
         end
         if (set_wb) begin
            wb_pend = 1; fin_armed = 1; fin_timer = fdel;
         end
         if (abort_at >= 0 && beat == abort_at) break;
      end

      if (abort_at >= 0) begin
         @(negedge clk);
         start = 1'b0; psum_in_valid = 1'b1; write_back_finish = 1'b0;
         rst_n = 1'b0;
         #1;
         model_reset();
         check_outputs(1'b0, 1'b0, 1'b0);
         @(negedge clk);
         rst_n = 1'b1;
         psum_in_valid = 1'b0;
         #1;
         check_outputs(1'b0, 1'b0, 1'b0);
      end else begin
         chk("job_ended", 32'(ended), 32'd1);
         @(negedge clk);
         start = 1'b0; psum_in_valid = 1'b0; write_back_finish = 1'b0;
         #1;
         check_outputs(1'b0, 1'b0, 1'b0);
         e_done = 1'b0;
`ifdef FM_GUARD_CTRL_PERF_EN
         chk("perf_beats", perf_beats, 32'(total));
         chk("perf_stall", perf_stall, 32'(stalls));
`endif
      end
   endtask

   task automatic cfg_err_job();
      @(negedge clk);
      start = 1'b1; w_num = 8'd4; h_num = 8'd3; c_num = 8'd0; o_num = 8'd1;
      psum_in_valid = 1'b1; write_back_finish = 1'b0;
      #1;
      check_outputs(1'b0, 1'b0, 1'b0);
      e_cfg_err = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check_outputs(1'b0, 1'b0, 1'b0);
      e_cfg_err = 1'b0;
      @(negedge clk);
      #1;
      check_outputs(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_outputs(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      run_job(4, 3, 1, 1, 100, 5, -1, 1'b0);
      run_job(2, 2, 2, 2, 100, 20, -1, 1'b0);
      run_job(3, 6, 1, 1, 100, 3, -1, 1'b0);
      run_job(1, 1, 1, 1, 100, 1, -1, 1'b0);
      cfg_err_job();
      run_job(4, 3, 1, 1, 100, 5, -1, 1'b1);
      run_job(4, 3, 1, 1, 100, 5, 5, 1'b0);
      run_job(4, 3, 1, 1, 100, 5, -1, 1'b0);
      run_job(4, 3, 1, 1, 50, 5, -1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         run_job($urandom_range(1, 4), $urandom_range(1, 5), $urandom_range(1, 3),
                 $urandom_range(1, 3), $urandom_range(30, 100), $urandom_range(1, 8),
                 -1, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
